// File: rtl/datapath_pkg.sv
// datapath_pkg: constants shared by the datapath, its ALU and the bench.
//   - ALU opcode values carried on ALU_Sel
//   - bus-source / register-enable bit indices
//   - CON condition codes (IR[20:19])
//   - RAM geometry and the C-operand sign-extension helper
package datapath_pkg;

  // ALU opcodes
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_SHR  = 6'd4;
  localparam logic [5:0] OP_SHRA = 6'd5;
  localparam logic [5:0] OP_SHL  = 6'd6;
  localparam logic [5:0] OP_ROR  = 6'd7;
  localparam logic [5:0] OP_ROL  = 6'd8;
  localparam logic [5:0] OP_MUL  = 6'd9;
  localparam logic [5:0] OP_DIV  = 6'd10;
  localparam logic [5:0] OP_NEG  = 6'd11;
  localparam logic [5:0] OP_NOT  = 6'd12;

  // Bus-source / enable bit positions
  localparam int IDX_HI  = 16;
  localparam int IDX_LO  = 17;
  localparam int IDX_ZHI = 18;
  localparam int IDX_ZLO = 19;
  localparam int IDX_PC  = 20;
  localparam int IDX_IR  = 21;
  localparam int IDX_MDR = 22;
  localparam int IDX_MAR = 23;
  localparam int IDX_Y   = 24;
  localparam int IDX_C   = 25;

  // Bits of enc_input that name a real bus source: R0-R15, HI, LO, ZHI,
  // ZLO, PC (0-20), MDR (22) and C (25). IR, MAR and Y are load-only.
  localparam logic [31:0] SRC_MASK = 32'h025F_FFFF;

  // CON condition codes
  typedef enum logic [1:0] {
    CON_EQ0 = 2'b00,
    CON_NE0 = 2'b01,
    CON_GE0 = 2'b10,
    CON_LT0 = 2'b11
  } con_code_e;

  localparam int RAM_DEPTH = 512;
  localparam int RAM_AW    = 9;

  function automatic logic [31:0] sext19(input logic [18:0] v);
    return {{13{v[18]}}, v};
  endfunction

endpackage

// File: rtl/datapath_if.sv
// datapath_if: control/observation bundle between the control sequencer
// (master) and the datapath (slave).
//   enc_input   one-hot bus source select     reg_enable  register loads
//   ALU_Sel     ALU operation                 incPC       force Z = bus+1
//   read/write  MDR-from-RAM / RAM[MAR]<=MDR  Gra/Grb/Grc field selects
//   Rin/Rout/BAout selected-register controls conIn      load CON
//   bus_contents, Mdatain, CONFFOut           observed by the master
interface datapath_if;
  logic [31:0] bus_contents;
  logic [31:0] enc_input;
  logic [5:0]  ALU_Sel;
  logic [31:0] Mdatain;
  logic        read;
  logic        write;
  logic [31:0] reg_enable;
  logic        incPC;
  logic [3:0]  Gra;
  logic [3:0]  Grb;
  logic [3:0]  Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        conIn;
  logic        CONFFOut;

  modport master (
    output enc_input, ALU_Sel, read, write, reg_enable, incPC,
           Gra, Grb, Grc, Rin, Rout, BAout, conIn,
    input  bus_contents, Mdatain, CONFFOut
  );

  modport slave (
    input  enc_input, ALU_Sel, read, write, reg_enable, incPC,
           Gra, Grb, Grc, Rin, Rout, BAout, conIn,
    output bus_contents, Mdatain, CONFFOut
  );
endinterface

// File: rtl/datapath_alu.sv
// datapath_alu: combinational 64-bit-result ALU.
//   a       Y register (first operand)
//   b       bus value (second operand, shift amount b[4:0])
//   op      ALU_Sel opcode
//   inc_pc  overrides op: result = b + 1
//   result  {ZHI, ZLO}
// Build option: DATAPATH_MULDIV_EN enables signed multiply and divide;
// without it ops 9/10 return zero and no multiplier/divider exists.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  op,
  input  logic        inc_pc,
  output logic [63:0] result
);

  logic [4:0]  sh;
  logic [63:0] ror_w;
  logic [63:0] rol_w;

  assign sh = b[4:0];
  // Rotates via a doubled operand: low half of the right shift, high half
  // of the left shift.
  assign ror_w = {a, a} >> sh;
  assign rol_w = {a, a} << sh;

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] prod;
  logic        [31:0] b_safe;
  logic signed [31:0] quo;
  logic signed [31:0] rem;

  assign prod   = $signed(a) * $signed(b);
  // Keeps the divider free of a zero divisor; the result is discarded then.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign quo    = $signed(a) / $signed(b_safe);
  assign rem    = $signed(a) % $signed(b_safe);
`endif

  always_comb begin
    result = '0;
    if (inc_pc) begin
      result[31:0] = b + 32'd1;
    end else begin
      case (op)
        OP_ADD:  result[31:0] = a + b;
        OP_SUB:  result[31:0] = a - b;
        OP_AND:  result[31:0] = a & b;
        OP_OR:   result[31:0] = a | b;
        OP_SHR:  result[31:0] = a >> sh;
        OP_SHRA: result[31:0] = $signed(a) >>> sh;
        OP_SHL:  result[31:0] = a << sh;
        OP_ROR:  result[31:0] = ror_w[31:0];
        OP_ROL:  result[31:0] = rol_w[63:32];
`ifdef DATAPATH_MULDIV_EN
        OP_MUL:  result = prod;
        OP_DIV:  result = (b == 32'd0) ? 64'd0 : {rem, quo};
`endif
        OP_NEG:  result[31:0] = 32'd0 - b;
        OP_NOT:  result[31:0] = ~b;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// datapath: single-bus 32-bit processor datapath.
//   clock   rising-edge clock
//   clr     asynchronous active-high reset (registers and CON, not RAM)
//   bus_if  datapath_if.slave: control inputs from the sequencer, bus,
//           RAM read data and branch flag back out
// Build option: DATAPATH_MULDIV_EN (passed through to datapath_alu).
module datapath
  import datapath_pkg::*;
(
  input  logic       clock,
  input  logic       clr,
  datapath_if.slave  bus_if
);

  logic [31:0] r_reg [16];
  logic [31:0] hi_reg, lo_reg, zhi_reg, zlo_reg, pc_reg, mdr_reg, y_reg;
  // IR and MAR are never bus sources, so only the decoded/used bits exist.
  logic [26:0] ir_reg;
  logic [RAM_AW-1:0] mar_reg;
  logic        con_reg;
  // Power-up contents are zero (bitstream init); clr leaves RAM alone.
  logic [31:0] ram [RAM_DEPTH];

  logic [31:0] bus;
  logic [31:0] src [32];
  logic [31:0] enc_valid;
  logic [31:0] en;
  logic [3:0]  ra, rb, rc, sel;
  logic [1:0]  c2;
  logic [31:0] sel_val;
  logic [31:0] mdr_in;
  logic [63:0] alu_result;
  logic        hit;
  logic        cond;
  logic        unused_en;

  assign en        = bus_if.reg_enable;
  assign enc_valid = bus_if.enc_input & SRC_MASK;
  // Enable 18 and 25-31 have no register behind them.
  assign unused_en = ^{en[31:25], en[IDX_ZHI]};

  assign ra = ir_reg[26:23];
  assign rb = ir_reg[22:19];
  assign rc = ir_reg[18:15];
  assign c2 = ir_reg[20:19];

  // Register select; R15 acts as link register when no field is asserted.
  always_comb begin
    sel = 4'd15;
    if (bus_if.Gra != 4'd0)      sel = ra;
    else if (bus_if.Grb != 4'd0) sel = rb;
    else if (bus_if.Grc != 4'd0) sel = rc;
  end
  assign sel_val = r_reg[sel];

  // Bus-source table indexed like enc_input; load-only slots read zero.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_src_gpr
      assign src[gi] = r_reg[gi];
    end
    for (gi = 26; gi < 32; gi++) begin : g_src_none
      assign src[gi] = '0;
    end
  endgenerate
  assign src[IDX_HI]  = hi_reg;
  assign src[IDX_LO]  = lo_reg;
  assign src[IDX_ZHI] = zhi_reg;
  assign src[IDX_ZLO] = zlo_reg;
  assign src[IDX_PC]  = pc_reg;
  assign src[IDX_IR]  = '0;
  assign src[IDX_MDR] = mdr_reg;
  assign src[IDX_MAR] = '0;
  assign src[IDX_Y]   = '0;
  assign src[IDX_C]   = sext19(ir_reg[18:0]);

  // Lowest-indexed source wins; the selected register only drives when no
  // enc_input source does. BAout reads R0 as constant zero.
  always_comb begin
    bus = '0;
    hit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!hit && enc_valid[i]) begin
        bus = src[i];
        hit = 1'b1;
      end
    end
    if (!hit) begin
      if (bus_if.Rout)       bus = sel_val;
      else if (bus_if.BAout) bus = (sel == 4'd0) ? 32'd0 : sel_val;
    end
  end

  datapath_alu u_alu (
    .a      (y_reg),
    .b      (bus),
    .op     (bus_if.ALU_Sel),
    .inc_pc (bus_if.incPC),
    .result (alu_result)
  );

  always_comb begin
    case (con_code_e'(c2))
      CON_EQ0: cond = (bus == 32'd0);
      CON_NE0: cond = (bus != 32'd0);
      CON_GE0: cond = ~bus[31];
      CON_LT0: cond = bus[31];
      default: cond = 1'b0;
    endcase
  end

  // RAM read is combinational, so a same-cycle write+read captures the
  // pre-write word in MDR.
  assign mdr_in = bus_if.read ? ram[mar_reg] : bus;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r_reg[i] <= '0;
    end else begin
      // Rin and a direct enable on the same register collapse to one write.
      for (int i = 0; i < 16; i++) begin
        if (en[i] || (bus_if.Rin && (sel == 4'(i)))) r_reg[i] <= bus;
      end
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      zhi_reg <= '0;
      zlo_reg <= '0;
      pc_reg  <= '0;
      ir_reg  <= '0;
      mdr_reg <= '0;
      mar_reg <= '0;
      y_reg   <= '0;
      con_reg <= 1'b0;
    end else begin
      if (en[IDX_HI]) hi_reg <= bus;
      if (en[IDX_LO]) lo_reg <= bus;
      if (en[IDX_ZLO] || bus_if.incPC) begin
        zhi_reg <= alu_result[63:32];
        zlo_reg <= alu_result[31:0];
      end
      if (en[IDX_PC])  pc_reg  <= bus;
      if (en[IDX_IR])  ir_reg  <= bus[26:0];
      if (en[IDX_MDR]) mdr_reg <= mdr_in;
      if (en[IDX_MAR]) mar_reg <= bus[RAM_AW-1:0];
      if (en[IDX_Y])   y_reg   <= bus;
      if (bus_if.conIn) con_reg <= cond;
    end
  end

  always_ff @(posedge clock) begin
    if (bus_if.write) ram[mar_reg] <= mdr_reg;
  end

  assign bus_if.bus_contents = bus;
  assign bus_if.Mdatain      = ram[mar_reg];
  assign bus_if.CONFFOut     = con_reg;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  import datapath_pkg::*;

  logic clock = 1'b0;
  logic clr;
  datapath_if b ();

  datapath dut (
    .clock  (clock),
    .clr    (clr),
    .bus_if (b)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] bv;
    logic [31:0] lo;
    logic [31:0] hi;
  } alu_vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] rv;
    logic        exp;
  } br_vec_t;

  typedef struct {
    int          src;
    logic [31:0] exp;
  } sb_t;

  localparam int NV = 19;
  localparam int NB = 6;
  alu_vec_t av [NV];
  br_vec_t  bv [NB];
  sb_t      sbq [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic idle();
    b.enc_input  = '0;
    b.reg_enable = '0;
    b.ALU_Sel    = '0;
    b.read       = 1'b0;
    b.write      = 1'b0;
    b.incPC      = 1'b0;
    b.Gra        = '0;
    b.Grb        = '0;
    b.Grc        = '0;
    b.Rin        = 1'b0;
    b.Rout       = 1'b0;
    b.BAout      = 1'b0;
    b.conIn      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  // Drive one register onto the bus and compare mid-cycle.
  task automatic obs(input string name, input int src, input logic [31:0] exp);
    b.enc_input = 32'd1 << src;
    #1;
    check32(name, b.bus_contents, exp);
    idle();
  endtask

  // R14 <= 1 using incPC on an empty bus.
  task automatic setup_one();
    b.incPC = 1'b1; tick();
    b.enc_input = 32'd1 << IDX_ZLO; b.reg_enable = 32'd1 << 14; tick();
  endtask

  // Builds v in R[t] by shift-and-add through Y/Z, using R14 == 1.
  task automatic make_const(input int t, input logic [31:0] v);
    bit started = 0;
    b.reg_enable = 32'd1 << t; tick();
    for (int i = 31; i >= 0; i--) begin
      if (started) begin
        b.enc_input = 32'd1 << t;  b.reg_enable = 32'd1 << IDX_Y; tick();
        b.enc_input = 32'd1 << 14; b.ALU_Sel = OP_SHL; b.reg_enable = 32'd1 << IDX_ZLO; tick();
        b.enc_input = 32'd1 << IDX_ZLO; b.reg_enable = 32'd1 << t; tick();
      end
      if (v[i]) begin
        b.enc_input = 32'd1 << t;  b.reg_enable = 32'd1 << IDX_Y; tick();
        b.enc_input = 32'd1 << 14; b.ALU_Sel = OP_ADD; b.reg_enable = 32'd1 << IDX_ZLO; tick();
        b.enc_input = 32'd1 << IDX_ZLO; b.reg_enable = 32'd1 << t; tick();
        started = 1;
      end
    end
  endtask

  initial begin
    sb_t e;
    idle();
    clr = 1'b1;
    #2;
    check32("rst_bus", b.bus_contents, 32'd0);
    check32("rst_con", {31'd0, b.CONFFOut}, 32'd0);
    check32("rst_mdatain", b.Mdatain, 32'd0);
    clr = 1'b0;

    av[0]  = '{OP_ADD,  32'd7,          32'd3,      32'd10,         32'd0};
    av[1]  = '{OP_SUB,  32'd7,          32'd3,      32'd4,          32'd0};
    av[2]  = '{OP_AND,  32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 32'd0};
    av[3]  = '{OP_OR,   32'h0000_F0F0,  32'h0000_FF00, 32'h0000_FFF0, 32'd0};
    av[4]  = '{OP_SHR,  32'h8000_0000,  32'd4,      32'h0800_0000,  32'd0};
    av[5]  = '{OP_SHRA, 32'h8000_0000,  32'd4,      32'hF800_0000,  32'd0};
    av[6]  = '{OP_SHL,  32'd7,          32'd3,      32'd56,         32'd0};
    av[7]  = '{OP_SHL,  32'd1,          32'd33,     32'd2,          32'd0};
    av[8]  = '{OP_ROR,  32'd1,          32'd1,      32'h8000_0000,  32'd0};
    av[9]  = '{OP_ROR,  32'h12,         32'd0,      32'h12,         32'd0};
    av[10] = '{OP_ROL,  32'h8000_0001,  32'd4,      32'h0000_0018,  32'd0};
    av[11] = '{OP_NEG,  32'd5,          32'd3,      32'hFFFF_FFFD,  32'd0};
    av[12] = '{OP_NOT,  32'd5,          32'h0000_F0F0, 32'hFFFF_0F0F, 32'd0};
    av[13] = '{OP_ADD,  32'hFFFF_FFFF,  32'd1,      32'd0,          32'd0};
    av[14] = '{6'd13,   32'd7,          32'd3,      32'd0,          32'd0};
`ifdef DATAPATH_MULDIV_EN
    av[15] = '{OP_MUL,  32'd7,          32'd3,      32'd21,         32'd0};
    av[16] = '{OP_MUL,  32'hFFFF_FFFE,  32'd3,      32'hFFFF_FFFA,  32'hFFFF_FFFF};
    av[17] = '{OP_DIV,  32'd7,          32'd3,      32'd2,          32'd1};
`else
    av[15] = '{OP_MUL,  32'd7,          32'd3,      32'd0,          32'd0};
    av[16] = '{OP_MUL,  32'hFFFF_FFFE,  32'd3,      32'd0,          32'd0};
    av[17] = '{OP_DIV,  32'd7,          32'd3,      32'd0,          32'd0};
`endif
    av[18] = '{OP_DIV,  32'd7,          32'd0,      32'd0,          32'd0};

    bv[0] = '{32'h0088_0000, 32'd9,         1'b1};
    bv[1] = '{32'h0088_0000, 32'd0,         1'b0};
    bv[2] = '{32'h0080_0000, 32'd0,         1'b1};
    bv[3] = '{32'h0090_0000, 32'h8000_0000, 1'b0};
    bv[4] = '{32'h0090_0000, 32'd0,         1'b1};
    bv[5] = '{32'h0098_0000, 32'h8000_0000, 1'b1};

    setup_one();
    obs("one_r14", 14, 32'd1);

    // Bus priority; IR (21) is not a source and must not win.
    make_const(1, 32'h11);
    make_const(2, 32'h22);
    b.enc_input = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << IDX_PC); #1;
    check32("prio_low_wins", b.bus_contents, 32'h11); idle();
    b.enc_input = (32'd1 << IDX_IR) | (32'd1 << 2) | (32'd1 << IDX_Y); #1;
    check32("prio_skip_ir", b.bus_contents, 32'h22); idle();

    // ALU table: expected Z halves queued when the op is driven.
    for (int i = 0; i < NV; i++) begin
      make_const(1, av[i].a);
      make_const(2, av[i].bv);
      b.enc_input = 32'd1 << 1; b.reg_enable = 32'd1 << IDX_Y; tick();
      b.enc_input = 32'd1 << 2; b.ALU_Sel = av[i].op; b.reg_enable = 32'd1 << IDX_ZLO;
      sbq.push_back('{IDX_ZLO, av[i].lo});
      sbq.push_back('{IDX_ZHI, av[i].hi});
      tick();
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        obs($sformatf("alu%0d_op%0d_%s", i, av[i].op, (e.src == IDX_ZLO) ? "zlo" : "zhi"), e.src, e.exp);
      end
    end

    // Fetch: PC=5, RAM[5]=0x12345678.
    make_const(3, 32'd5);
    b.enc_input = 32'd1 << 3; b.reg_enable = 32'd1 << IDX_PC; tick();
    make_const(4, 32'h1234_5678);
    b.enc_input = 32'd1 << 4; b.reg_enable = 32'd1 << IDX_MDR; tick();
    b.enc_input = 32'd1 << 3; b.reg_enable = 32'd1 << IDX_MAR; tick();
    b.write = 1'b1; tick();
    check32("ram_write", b.Mdatain, 32'h1234_5678);
    b.reg_enable = 32'd1 << IDX_MAR; tick();
    check32("mar_zero_ram0", b.Mdatain, 32'd0);
    b.enc_input = 32'd1 << IDX_PC; b.reg_enable = 32'd1 << IDX_MAR; b.incPC = 1'b1; tick();
    b.enc_input = 32'd1 << IDX_ZLO; b.reg_enable = (32'd1 << IDX_PC) | (32'd1 << IDX_MDR);
    b.read = 1'b1; tick();
    b.enc_input = 32'd1 << IDX_MDR; b.reg_enable = 32'd1 << IDX_IR; tick();
    check32("fetch_mar", b.Mdatain, 32'h1234_5678);
    obs("fetch_pc", IDX_PC, 32'd6);
    obs("fetch_mdr", IDX_MDR, 32'h1234_5678);
    obs("fetch_ir_c", IDX_C, 32'hFFFC_5678);

    // JAL: link into R15, jump to R[ra].
    make_const(5, 32'h0088_0000);
    b.enc_input = 32'd1 << 5; b.reg_enable = 32'd1 << IDX_IR; tick();
    make_const(1, 32'h40);
    b.enc_input = 32'd1 << IDX_PC; b.Rin = 1'b1; tick();
    b.Rout = 1'b1; #1;
    check32("jal_link_r15", b.bus_contents, 32'd6); idle();
    b.Gra = 4'd1; b.Rout = 1'b1; b.reg_enable = 32'd1 << IDX_PC; tick();
    obs("jal_pc", IDX_PC, 32'h40);
    b.enc_input = 32'd1 << IDX_PC; b.Grc = 4'd1; b.Rin = 1'b1; b.reg_enable = 32'd1; tick();
    obs("rin_and_en_r0", 0, 32'h40);

    // Branch condition table.
    for (int i = 0; i < NB; i++) begin
      make_const(3, bv[i].ir);
      b.enc_input = 32'd1 << 3; b.reg_enable = 32'd1 << IDX_IR; tick();
      make_const(1, bv[i].rv);
      b.Gra = 4'd1; b.Rout = 1'b1; b.conIn = 1'b1; tick();
      check32($sformatf("con%0d_c2_%0d", i, bv[i].ir[20:19]), {31'd0, b.CONFFOut}, {31'd0, bv[i].exp});
    end

    // BAout reads R0 as zero; Rout does not.
    make_const(5, 32'h0080_0000);
    b.enc_input = 32'd1 << 5; b.reg_enable = 32'd1 << IDX_IR; tick();
    make_const(0, 32'h0000_FFFF);
    b.Grb = 4'd1; b.BAout = 1'b1; #1;
    check32("baout_r0", b.bus_contents, 32'd0); idle();
    b.Grb = 4'd1; b.Rout = 1'b1; #1;
    check32("rout_r0", b.bus_contents, 32'h0000_FFFF); idle();
    b.Gra = 4'd1; b.BAout = 1'b1; #1;
    check32("baout_r1", b.bus_contents, 32'h8000_0000); idle();

    // Same-cycle write+read at MAR=5.
    make_const(4, 32'hCAFE_0001);
    b.enc_input = 32'd1 << 4; b.reg_enable = 32'd1 << IDX_MDR; tick();
    b.write = 1'b1; b.read = 1'b1; b.reg_enable = 32'd1 << IDX_MDR; tick();
    obs("wr_rd_mdr_old", IDX_MDR, 32'h1234_5678);
    check32("wr_rd_ram_new", b.Mdatain, 32'hCAFE_0001);

    // clr mid-cycle with CON set and PC on the bus.
    b.conIn = 1'b1; tick();
    check32("con_set_pre_clr", {31'd0, b.CONFFOut}, 32'd1);
    b.enc_input = 32'd1 << IDX_PC; #1;
    check32("bus_pre_clr", b.bus_contents, 32'h40);
    clr = 1'b1; #1;
    check32("clr_bus", b.bus_contents, 32'd0);
    check32("clr_con", {31'd0, b.CONFFOut}, 32'd0);
    clr = 1'b0; idle();
    obs("clr_r1", 1, 32'd0);
    obs("clr_r15", 15, 32'd0);
    obs("clr_mdr", IDX_MDR, 32'd0);
    obs("clr_zlo", IDX_ZLO, 32'd0);
    setup_one();
    make_const(3, 32'd5);
    b.enc_input = 32'd1 << 3; b.reg_enable = 32'd1 << IDX_MAR; tick();
    check32("ram_retained", b.Mdatain, 32'hCAFE_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
